// File: rtl/dc_bu_line_scheduler_pkg.sv
// Shared constants, state encoding and modular index helper for the
// buffering-unit line scheduler.
package dc_bu_pkg;

  localparam int BUFFER_NUM = 5;
  localparam int WINDOW     = 4;

  localparam logic [BUFFER_NUM-1:0] BUFF_0 = 5'b00001;
  localparam logic [BUFFER_NUM-1:0] BUFF_1 = 5'b00010;
  localparam logic [BUFFER_NUM-1:0] BUFF_2 = 5'b00100;
  localparam logic [BUFFER_NUM-1:0] BUFF_3 = 5'b01000;
  localparam logic [BUFFER_NUM-1:0] BUFF_4 = 5'b10000;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    STALL,
    EOF
  } sched_state_t;

  // Operands stay below 5 (b may be 5 for a full ring), so one conditional
  // subtract brings the sum back into 0..4.
  function automatic logic [2:0] mod5_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd5) begin
      s = s - 4'd5;
    end
    return s[2:0];
  endfunction

endpackage

// File: rtl/dc_bu_line_scheduler_if.sv
// Control/select bundle between the line scheduler and its writer/scaler peers.
interface dc_bu_line_scheduler_if;
  import dc_bu_pkg::*;

  logic                  en;
  logic                  frame_start;
  logic                  wr_line_done;
  logic                  wr_last_line;
  logic                  rd_line_done;
  logic                  rd_advance;
  logic [BUFFER_NUM-1:0] wr_buff;
  logic                  wr_ready;
  logic [BUFFER_NUM-1:0] y0_buff;
  logic [BUFFER_NUM-1:0] y1_buff;
  logic [BUFFER_NUM-1:0] y2_buff;
  logic [BUFFER_NUM-1:0] y3_buff;
  logic                  output_en;
  logic                  next_line;
  logic                  overflow_err;

  modport slave (
    input  en, frame_start, wr_line_done, wr_last_line, rd_line_done, rd_advance,
    output wr_buff, wr_ready, y0_buff, y1_buff, y2_buff, y3_buff,
           output_en, next_line, overflow_err
  );

  modport master (
    output en, frame_start, wr_line_done, wr_last_line, rd_line_done, rd_advance,
    input  wr_buff, wr_ready, y0_buff, y1_buff, y2_buff, y3_buff,
           output_en, next_line, overflow_err
  );

endinterface

// File: rtl/dc_bu_line_scheduler_onehot_rot.sv
// One-hot select of ring slot (base + min(OFFSET, lim)) mod 5.
module dc_bu_onehot_rot
  import dc_bu_pkg::*;
#(
  parameter logic [2:0] OFFSET = 3'd0
) (
  input  logic [2:0]            base,
  input  logic [2:0]            lim,
  output logic [BUFFER_NUM-1:0] sel
);

  logic [2:0] offs;
  logic [2:0] idx;

  // lim lets a short window replicate its newest line downward
  assign offs = (OFFSET > lim) ? lim : OFFSET;
  assign idx  = mod5_add(base, offs);

  for (genvar gi = 0; gi < BUFFER_NUM; gi++) begin : g_sel
    assign sel[gi] = (idx == 3'(gi));
  end

endmodule

// File: rtl/dc_bu_line_scheduler.sv
// Rotates five line buffers between the writer and a sliding 4-line read
// window, covering fill, steady state, writer stall and bottom clamping.
module dc_bu_line_scheduler
  import dc_bu_pkg::*;
(
  input logic                    clk,
  input logic                    nrst,
  dc_bu_line_scheduler_if.slave  bus
);

  sched_state_t state_reg, state_next;
  logic [2:0]   rd_ptr_reg, rd_ptr_next;
  logic [2:0]   cnt_reg, cnt_next;
  logic         eof_reg, eof_next;
  logic         next_line_reg, next_line_next;
  logic         overflow_reg, overflow_next;

  logic         wr_ready;
  logic         accept;
  logic [2:0]   rd_inc;
  logic [2:0]   wr_ptr;
  logic [2:0]   lim;

  assign wr_ready = (state_reg != IDLE) && !eof_reg && (cnt_reg < 3'd5);
  assign accept   = bus.wr_line_done && wr_ready;
  assign rd_inc   = mod5_add(rd_ptr_reg, 3'd1);
  assign wr_ptr   = mod5_add(rd_ptr_reg, cnt_reg);
  assign lim      = ((cnt_reg != 3'd0) && (cnt_reg < 3'd4)) ? (cnt_reg - 3'd1) : 3'd4;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      rd_ptr_reg    <= 3'd0;
      cnt_reg       <= 3'd0;
      eof_reg       <= 1'b0;
      next_line_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rd_ptr_reg    <= rd_ptr_next;
      cnt_reg       <= cnt_next;
      eof_reg       <= eof_next;
      next_line_reg <= next_line_next;
      overflow_reg  <= overflow_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rd_ptr_next    = rd_ptr_reg;
    cnt_next       = cnt_reg;
    eof_next       = eof_reg;
    next_line_next = 1'b0;
    overflow_next  = overflow_reg;

    if (bus.en) begin
      if (bus.frame_start) begin
        state_next  = FILL;
        rd_ptr_next = 3'd0;
        cnt_next    = 3'd0;
        eof_next    = 1'b0;
      end else begin
        if (bus.wr_line_done && !wr_ready) begin
          overflow_next = 1'b1;
        end
        case (state_reg)
          FILL: begin
            if (accept) begin
              cnt_next = cnt_reg + 3'd1;
              if (bus.wr_last_line) begin
                state_next     = EOF;
                eof_next       = 1'b1;
                next_line_next = 1'b1;
              end else if (cnt_reg == 3'd3) begin
                state_next     = RUN;
                next_line_next = 1'b1;
              end
            end
          end
          RUN: begin
            if (accept) begin
              cnt_next = cnt_reg + 3'd1;
              if (bus.wr_last_line) begin
                state_next = EOF;
                eof_next   = 1'b1;
              end
            end
            if (bus.rd_line_done) begin
              if (!bus.rd_advance) begin
                next_line_next = 1'b1;
              end else if (cnt_reg == 3'd5) begin
                rd_ptr_next    = rd_inc;
                cnt_next       = 3'd4;
                next_line_next = 1'b1;
              end else if (accept) begin
                // write and advance cancel out in the line count
                rd_ptr_next    = rd_inc;
                cnt_next       = cnt_reg;
                next_line_next = 1'b1;
              end else begin
                state_next = STALL;
              end
            end
          end
          STALL: begin
            if (accept) begin
              rd_ptr_next    = rd_inc;
              state_next     = bus.wr_last_line ? EOF : RUN;
              eof_next       = bus.wr_last_line;
              next_line_next = 1'b1;
            end
          end
          EOF: begin
            if (bus.rd_line_done) begin
              next_line_next = 1'b1;
              if (bus.rd_advance && (cnt_reg > 3'd4)) begin
                rd_ptr_next = rd_inc;
                cnt_next    = cnt_reg - 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [BUFFER_NUM-1:0] y_sel [WINDOW];

  for (genvar gi = 0; gi < WINDOW; gi++) begin : g_rd
    dc_bu_onehot_rot #(.OFFSET(3'(gi))) u_rd (
      .base (rd_ptr_reg),
      .lim  (lim),
      .sel  (y_sel[gi])
    );
  end

  dc_bu_onehot_rot #(.OFFSET(3'd0)) u_wr (
    .base (wr_ptr),
    .lim  (3'd4),
    .sel  (bus.wr_buff)
  );

  assign bus.y0_buff      = y_sel[0];
  assign bus.y1_buff      = y_sel[1];
  assign bus.y2_buff      = y_sel[2];
  assign bus.y3_buff      = y_sel[3];
  assign bus.wr_ready     = wr_ready;
  assign bus.output_en    = (state_reg == RUN) || (state_reg == EOF);
  assign bus.next_line    = next_line_reg;
  assign bus.overflow_err = overflow_reg;

endmodule

// File: tb/tb_dc_bu_line_scheduler.sv
// Directed vector table plus randomized run against a queue-based model.
module tb_dc_bu_line_scheduler;
  import dc_bu_pkg::*;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  dc_bu_line_scheduler_if bus();

  dc_bu_line_scheduler dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct {
    bit          en, fs, wd, wl, rd, ra;
    logic [28:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model: buffers currently held, oldest first
  int q[$];
  int wr_id;
  bit active, showing, stalled, ended, m_ovf, m_nl;

  function automatic logic [4:0] oh(input int i);
    logic [4:0] one;
    one = 5'd1;
    return one << i;
  endfunction

  function automatic logic [28:0] pack(input int y0, y1, y2, y3, wr,
                                       input bit rdy, oe, nl, ovf);
    return {oh(y0), oh(y1), oh(y2), oh(y3), oh(wr), rdy, oe, nl, ovf};
  endfunction

  function automatic void mk(input bit en, fs, wd, wl, rd, ra,
                             input int y0, y1, y2, y3, wr,
                             input bit rdy, oe, nl, ovf);
    vec_t v;
    v.en = en; v.fs = fs; v.wd = wd; v.wl = wl; v.rd = rd; v.ra = ra;
    v.exp = pack(y0, y1, y2, y3, wr, rdy, oe, nl, ovf);
    vecs.push_back(v);
  endfunction

  function automatic logic [28:0] dut_vec();
    return {bus.y0_buff, bus.y1_buff, bus.y2_buff, bus.y3_buff, bus.wr_buff,
            bus.wr_ready, bus.output_en, bus.next_line, bus.overflow_err};
  endfunction

  function automatic void model_reset();
    q.delete();
    wr_id = 0; active = 0; showing = 0; stalled = 0; ended = 0;
    m_ovf = 0; m_nl = 0;
  endfunction

  function automatic logic [28:0] model_vec();
    int yi[4];
    int n;
    n = q.size();
    for (int k = 0; k < 4; k++) begin
      yi[k] = (n == 0) ? k : q[(k < n) ? k : n - 1];
    end
    return pack(yi[0], yi[1], yi[2], yi[3], wr_id,
                active && !ended && (n < 5), showing && !stalled, m_nl, m_ovf);
  endfunction

  function automatic void push_line();
    q.push_back(wr_id);
    wr_id = (wr_id + 1) % 5;
  endfunction

  function automatic void model_step(input bit en, fs, wd, wl, rd, ra);
    bit rdy, acc, was_ended;
    int n;
    m_nl = 0;
    if (!en) return;
    if (fs) begin
      q.delete();
      wr_id = 0; active = 1; showing = 0; stalled = 0; ended = 0;
      return;
    end
    n         = q.size();
    rdy       = active && !ended && (n < 5);
    acc       = wd && rdy;
    was_ended = ended;
    if (wd && !rdy) m_ovf = 1;
    if (!active) return;
    if (!showing) begin
      if (acc) begin
        push_line();
        ended = wl;
        if (q.size() == 4 || wl) begin
          showing = 1;
          m_nl    = 1;
        end
      end
    end else if (stalled) begin
      if (acc) begin
        push_line();
        void'(q.pop_front());
        stalled = 0;
        ended   = wl;
        m_nl    = 1;
      end
    end else begin
      if (acc) begin
        push_line();
        if (wl) ended = 1;
      end
      if (rd && !ra) m_nl = 1;
      if (rd && ra) begin
        if (n > 4) begin
          void'(q.pop_front());
          m_nl = 1;
        end else if (was_ended) begin
          m_nl = 1;
        end else if (acc) begin
          void'(q.pop_front());
          m_nl = 1;
        end else begin
          stalled = 1;
        end
      end
    end
  endfunction

  task automatic drive(input bit en, fs, wd, wl, rd, ra);
    bus.en = en; bus.frame_start = fs; bus.wr_line_done = wd;
    bus.wr_last_line = wl; bus.rd_line_done = rd; bus.rd_advance = ra;
  endtask

  task automatic check(input string name, input logic [28:0] got, input logic [28:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  initial begin
    // fill, steady state, wrap-around
    mk(1,1,0,0,0,0, 0,1,2,3,0, 1,0,0,0);
    mk(1,0,1,0,0,0, 0,0,0,0,1, 1,0,0,0);
    mk(1,0,1,0,0,0, 0,1,1,1,2, 1,0,0,0);
    mk(1,0,1,0,0,0, 0,1,2,2,3, 1,0,0,0);
    mk(1,0,1,0,0,0, 0,1,2,3,4, 1,1,1,0);
    mk(1,0,0,0,0,0, 0,1,2,3,4, 1,1,0,0);
    mk(1,0,1,0,0,0, 0,1,2,3,0, 0,1,0,0);
    mk(1,0,0,0,1,1, 1,2,3,4,0, 1,1,1,0);
    // stall, then a write three cycles later
    mk(1,0,0,0,1,1, 1,2,3,4,0, 1,0,0,0);
    mk(1,0,0,0,0,0, 1,2,3,4,0, 1,0,0,0);
    mk(1,0,0,0,0,0, 1,2,3,4,0, 1,0,0,0);
    mk(1,0,1,0,0,0, 2,3,4,0,1, 1,1,1,0);
    // window reuse
    mk(1,0,0,0,1,0, 2,3,4,0,1, 1,1,1,0);
    mk(1,0,0,0,1,0, 2,3,4,0,1, 1,1,1,0);
    mk(1,0,0,0,1,0, 2,3,4,0,1, 1,1,1,0);
    mk(1,0,0,0,0,0, 2,3,4,0,1, 1,1,0,0);
    // overflow, last line, bottom clamp
    mk(1,0,1,0,0,0, 2,3,4,0,2, 0,1,0,0);
    mk(1,0,1,0,0,0, 2,3,4,0,2, 0,1,0,1);
    mk(1,0,0,0,1,1, 3,4,0,1,2, 1,1,1,1);
    mk(1,0,1,1,0,0, 3,4,0,1,3, 0,1,0,1);
    mk(1,0,0,0,1,1, 4,0,1,2,3, 0,1,1,1);
    mk(1,0,0,0,1,1, 4,0,1,2,3, 0,1,1,1);
    mk(1,0,0,0,1,1, 4,0,1,2,3, 0,1,1,1);
    // new frame, stall, frame_start during stall
    mk(1,1,0,0,0,0, 0,1,2,3,0, 1,0,0,1);
    mk(1,0,1,0,0,0, 0,0,0,0,1, 1,0,0,1);
    mk(1,0,1,0,0,0, 0,1,1,1,2, 1,0,0,1);
    mk(1,0,1,0,0,0, 0,1,2,2,3, 1,0,0,1);
    mk(1,0,1,0,0,0, 0,1,2,3,4, 1,1,1,1);
    mk(1,0,0,0,1,1, 0,1,2,3,4, 1,0,0,1);
    mk(1,1,0,0,0,0, 0,1,2,3,0, 1,0,0,1);
    // short frame, then en low blocks everything
    mk(1,0,1,0,0,0, 0,0,0,0,1, 1,0,0,1);
    mk(1,0,1,1,0,0, 0,1,1,1,2, 0,1,1,1);
    mk(1,0,0,0,1,1, 0,1,1,1,2, 0,1,1,1);
    mk(0,1,0,0,1,0, 0,1,1,1,2, 0,1,0,1);
    mk(1,0,1,0,0,0, 0,1,1,1,2, 0,1,0,1);

    drive(1,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    check("reset", dut_vec(), pack(0,1,2,3,0, 0,0,0,0));
    $display("reset vec=%b", dut_vec());
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].fs, vecs[i].wd, vecs[i].wl, vecs[i].rd, vecs[i].ra);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
      $display("vec %0d in=%b%b%b%b%b%b out=%b", i, vecs[i].en, vecs[i].fs, vecs[i].wd,
               vecs[i].wl, vecs[i].rd, vecs[i].ra, dut_vec());
    end

    // asynchronous reset mid-cycle, then randomized traffic
    drive(1,0,0,0,0,0);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("async_reset", dut_vec(), pack(0,1,2,3,0, 0,0,0,0));
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 600; i++) begin
      bit en, fs, wd, wl, rd, ra;
      en = ($urandom_range(0, 9) != 0);
      fs = ($urandom_range(0, 59) == 0) || (i == 0);
      wd = ($urandom_range(0, 2) == 0);
      wl = wd && ($urandom_range(0, 11) == 0);
      rd = ($urandom_range(0, 2) == 0);
      ra = ($urandom_range(0, 3) != 0);
      drive(en, fs, wd, wl, rd, ra);
      model_step(en, fs, wd, wl, rd, ra);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", i), dut_vec(), model_vec());
      $display("rand %0d in=%b%b%b%b%b%b out=%b", i, en, fs, wd, wl, rd, ra, dut_vec());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dc_bu_line_scheduler.md
Name: dc_bu_line_scheduler

Overview:
- Rotation controller for the five line buffers in the buffering unit.
- Tells the line writer which buffer to fill next.
- Drives the one-hot read selects y0_buff..y3_buff and output_en/next_line for the line-ordering stage, forming a sliding 4-line vertical window.
- Handles fill, steady state, writer-starved stall and end-of-frame bottom-line clamping.

Parameters:
- BUFFER_NUM, 5, number of line buffers; one-hot select width. Only 5 is supported.
- WINDOW, 4, number of lines presented to the scaler (y0..y3).

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- en  in  1  global clock enable; no state changes while low
- frame_start  in  1  pulse; restart scheduling for a new frame
- wr_line_done  in  1  pulse; writer finished the line in wr_buff
- wr_last_line  in  1  qualifies wr_line_done; that line is the frame's last
- rd_line_done  in  1  pulse; scaler finished one output line from the window
- rd_advance  in  1  qualifies rd_line_done; 1 = slide window, 0 = reuse window (vertical upscale)
- wr_buff  out  BUFFER_NUM  one-hot buffer the writer must fill
- wr_ready  out  1  writer may write into wr_buff
- y0_buff..y3_buff  out  BUFFER_NUM each  one-hot read selects, y0 = oldest line
- output_en  out  1  window valid
- next_line  out  1  one-cycle pulse on every window change or reuse
- overflow_err  out  1  sticky; set by wr_line_done while wr_ready=0

Behaviour:
- State: rd_ptr (0..4, oldest line), cnt (0..5, completed lines held), FSM state, eof flag.
- Derived pointers:
  - wr_ptr = (rd_ptr+cnt) mod 5.
  - yk_buff = onehot((rd_ptr+k) mod 5).
  - wr_buff = onehot(wr_ptr).
  - All mod-5 adds use 3-bit compare-and-subtract, never a 3-bit wrap.
- Reset values:
  - rd_ptr=0, cnt=0, eof=0, state=IDLE.
  - wr_buff=BUFF_0, y0..y3_buff=BUFF_0..BUFF_3, wr_ready=0, output_en=0, next_line=0, overflow_err=0.
- Registered outputs:
  - wr_ready = (state!=IDLE) && !eof && cnt<5.
  - output_en = (state==RUN) || (state==EOF).
  - next_line is a registered pulse, high the cycle after the triggering event.
- FSM:
  - IDLE: wait for frame_start, then go to FILL.
  - FILL: each accepted wr_line_done does cnt++. When cnt reaches 4, go to RUN and pulse next_line. A wr_last_line before cnt=4 also goes to RUN/EOF: rd_ptr is kept and the missing lines reuse the newest buffer (yk clamped to index cnt-1).
  - RUN: rd_line_done&&!rd_advance pulses next_line only. rd_line_done&&rd_advance:
    - cnt==5: rd_ptr++, cnt--, pulse next_line.
    - cnt==4 with simultaneous wr_line_done: rd_ptr++, cnt unchanged, pulse next_line.
    - cnt==4 otherwise: go to STALL.
  - STALL: output_en=0. The next wr_line_done applies the pending advance (rd_ptr++), returns to RUN and pulses next_line.
  - EOF: entered on accepted wr_line_done with wr_last_line; eof=1 and wr_ready=0.
    - While cnt>4, an advance shifts normally.
    - While cnt==4, an advance keeps rd_ptr and clamps y3 (bottom replication), pulsing next_line.
    - Stay in EOF until frame_start.
- wr_line_done while wr_ready=0: ignored, sets overflow_err. Only a reset clears overflow_err.
- frame_start in any state, including mid-line or STALL, has priority over all other events in that cycle:
  - rd_ptr=0, cnt=0, eof=0, go to FILL.
  - output_en drops next cycle.
  - overflow_err is kept.
- en=0: all registers hold and pulses are not generated; events arriving during en=0 are lost (caller's responsibility).
- Latency: every event affects outputs exactly one cycle later.

Decomposition:
- Package dc_bu_pkg:
  - BUFFER_NUM and WINDOW constants.
  - One-hot constants BUFF_0..BUFF_4.
  - Enum typedef sched_state_t {IDLE, FILL, RUN, STALL, EOF}.
  - A function that returns the mod-5 index sum.
- Sub-module dc_bu_onehot_rot:
  - Inputs: 3-bit base index and constant offset.
  - Output: one-hot BUFFER_NUM select.
  - Instantiated five times: wr_buff plus four read selects.

Test Plan:
- Reset, frame_start, then 4 wr_line_done pulses -> cnt=4 and output_en=1 one cycle after the 4th pulse; y0..y3_buff = 00001, 00010, 00100, 01000; wr_buff=10000; single next_line pulse.
- Continue with a 5th write, then rd_line_done+rd_advance -> before the advance wr_ready=0; after it y0..y3_buff = 00010, 00100, 01000, 10000 and wr_buff=00001 (wrap-around).
- Advance at cnt=4 with no write -> output_en=0 (STALL); a write 3 cycles later -> output_en=1 and next_line pulse the following cycle, window shifted by one.
- rd_line_done with rd_advance=0, three times -> three next_line pulses, selects unchanged.
- wr_line_done at cnt=5 -> overflow_err=1 and stays high, cnt stays 5. Last line written, then advances down to cnt=4, one more advance -> y3_buff unchanged (clamp).
- frame_start during STALL -> next cycle output_en=0, wr_buff=00001, wr_ready=1, state FILL.
